// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation over the shuffled S memory: XORs the keystream
// with the encrypted ROM, writes the decrypted RAM and screens each byte.
module prga_decrypt #(
  parameter int MSG_LEN    = 32,
  parameter bit CHECK_TEXT = 1'b1,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [7:0]    s_q,
  output logic [7:0]    s_address,
  output logic [7:0]    s_data,
  output logic          s_wren,
  input  logic [7:0]    e_q,
  output logic [AW-1:0] e_address,
  output logic [AW-1:0] d_address,
  output logic [7:0]    d_data,
  output logic          d_wren,
  output logic          finish,
  output logic          key_ok
);

  localparam logic [AW-1:0] LAST = AW'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, INC, WAIT_I, READ_I, WAIT_J, READ_J,
    WRITE_I, WRITE_J, WAIT_F, READ_F, WRITE_D, DONE, FAIL
  } state_t;

  state_t state_q, state_d;

  logic [7:0]    i, j, si, sj;
  logic [AW-1:0] k;
  logic          abort;

  // Plausible plaintext: lowercase letters and space only.
  function automatic logic text_ok(input logic [7:0] b);
    return (b == 8'd32) || ((b >= 8'd97) && (b <= 8'd122));
  endfunction

  assign abort = CHECK_TEXT && !text_ok(d_data);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_wren  = 1'b0;
    d_wren  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = INC;
      INC:     state_d = WAIT_I;
      WAIT_I:  state_d = READ_I;
      READ_I:  state_d = WAIT_J;
      WAIT_J:  state_d = READ_J;
      READ_J:  state_d = WRITE_I;
      WRITE_I: begin
        s_wren  = 1'b1;
        state_d = WRITE_J;
      end
      WRITE_J: begin
        s_wren  = 1'b1;
        state_d = WAIT_F;
      end
      WAIT_F:  state_d = READ_F;
      READ_F:  state_d = WRITE_D;
      WRITE_D: begin
        d_wren = 1'b1;
        if (abort)          state_d = FAIL;
        else if (k == LAST) state_d = DONE;
        else                state_d = INC;
      end
      DONE, FAIL: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // key_ok is registered on entry to DONE/FAIL so it is valid alongside finish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i         <= '0;
      j         <= '0;
      si        <= '0;
      sj        <= '0;
      k         <= '0;
      s_address <= '0;
      s_data    <= '0;
      e_address <= '0;
      d_address <= '0;
      d_data    <= '0;
      key_ok    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          i      <= '0;
          j      <= '0;
          si     <= '0;
          sj     <= '0;
          k      <= '0;
          key_ok <= 1'b0;
        end
        INC: begin
          i         <= i + 8'd1;
          s_address <= i + 8'd1;
          e_address <= k;
        end
        READ_I: begin
          si        <= s_q;
          j         <= j + s_q;
          s_address <= j + s_q;
        end
        READ_J: begin
          sj        <= s_q;
          s_address <= i;
          s_data    <= s_q;
        end
        WRITE_I: begin
          s_address <= j;
          s_data    <= si;
        end
        WRITE_J: s_address <= si + sj;
        READ_F: begin
          d_data    <= s_q ^ e_q;
          d_address <= k;
        end
        WRITE_D: begin
          if (abort)          key_ok <= 1'b0;
          else if (k == LAST) key_ok <= 1'b1;
          else                k      <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: three configurations share one set of memory models,
// checked every cycle against a plain RC4 software model plus literal pins.
module tb_prga_decrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, init_s, go, chk_en;
  int         sel;
  logic [7:0] s_q, e_q;

  logic [7:0] sa_a, sd_a, dd_a, sa_b, sd_b, dd_b, sa_c, sd_c, dd_c;
  logic       sw_a, dw_a, fin_a, ok_a, sw_b, dw_b, fin_b, ok_b, sw_c, dw_c, fin_c, ok_c;
  logic [1:0] ea_a, da_a, ea_b, da_b;
  logic [7:0] ea_c, da_c;

  prga_decrypt #(.MSG_LEN(3), .CHECK_TEXT(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start && sel == 0), .s_q(s_q),
    .s_address(sa_a), .s_data(sd_a), .s_wren(sw_a), .e_q(e_q), .e_address(ea_a),
    .d_address(da_a), .d_data(dd_a), .d_wren(dw_a), .finish(fin_a), .key_ok(ok_a));

  prga_decrypt #(.MSG_LEN(3), .CHECK_TEXT(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start && sel == 1), .s_q(s_q),
    .s_address(sa_b), .s_data(sd_b), .s_wren(sw_b), .e_q(e_q), .e_address(ea_b),
    .d_address(da_b), .d_data(dd_b), .d_wren(dw_b), .finish(fin_b), .key_ok(ok_b));

  prga_decrypt #(.MSG_LEN(256), .CHECK_TEXT(1'b0)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start && sel == 2), .s_q(s_q),
    .s_address(sa_c), .s_data(sd_c), .s_wren(sw_c), .e_q(e_q), .e_address(ea_c),
    .d_address(da_c), .d_data(dd_c), .d_wren(dw_c), .finish(fin_c), .key_ok(ok_c));

  logic [7:0] m_sa, m_sd, m_ea, m_da, m_dd;
  logic       m_sw, m_dw, m_fin, m_ok;

  always_comb begin
    case (sel)
      0: begin
        m_sa = sa_a; m_sd = sd_a; m_ea = {6'b0, ea_a}; m_da = {6'b0, da_a}; m_dd = dd_a;
        m_sw = sw_a; m_dw = dw_a; m_fin = fin_a; m_ok = ok_a;
      end
      1: begin
        m_sa = sa_b; m_sd = sd_b; m_ea = {6'b0, ea_b}; m_da = {6'b0, da_b}; m_dd = dd_b;
        m_sw = sw_b; m_dw = dw_b; m_fin = fin_b; m_ok = ok_b;
      end
      default: begin
        m_sa = sa_c; m_sd = sd_c; m_ea = ea_c; m_da = da_c; m_dd = dd_c;
        m_sw = sw_c; m_dw = dw_c; m_fin = fin_c; m_ok = ok_c;
      end
    endcase
  end

  // Synchronous memories with one-cycle read latency.
  logic [7:0] smem [256];
  logic [7:0] dmem [256];
  logic [7:0] emem [256];

  always @(posedge clk) begin
    if (init_s) begin
      for (int n = 0; n < 256; n++) begin
        smem[n] <= 8'(n);
        dmem[n] <= 8'hEE;
      end
    end else begin
      if (m_sw) smem[m_sa] <= m_sd;
      if (m_dw) dmem[m_da] <= m_dd;
    end
    s_q <= smem[m_sa];
    e_q <= emem[m_ea];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Software RC4 model, run from the current S memory contents.
  logic [7:0] exp_d [256], exp_i [256], exp_j [256], exp_si [256], exp_sj [256];
  int         exp_n, exp_end;
  logic       exp_ok;

  task automatic build_model(input int len, input bit ck);
    logic [7:0] s [256];
    logic [7:0] ii, jj, a, b, d;
    for (int n = 0; n < 256; n++) s[n] = smem[n];
    ii = 0; jj = 0;
    exp_n = len; exp_ok = 1'b1;
    for (int n = 0; n < len; n++) begin
      ii = ii + 8'd1;
      a = s[ii];
      jj = jj + a;
      b = s[jj];
      s[ii] = b;
      s[jj] = a;
      d = s[8'(a + b)] ^ emem[n];
      exp_d[n] = d; exp_i[n] = ii; exp_j[n] = jj; exp_si[n] = a; exp_sj[n] = b;
      if (ck && !(d == 8'd32 || (d >= 8'd97 && d <= 8'd122))) begin
        exp_n = n + 1;
        exp_ok = 1'b0;
        break;
      end
    end
    exp_end = 10 * exp_n + 1;
  endtask

  // cyc = 1 in the first cycle after the accepted start.
  int cyc = 0;
  always @(posedge clk) begin
    if (go) cyc <= 1;
    else if (!chk_en || cyc == 0 || cyc >= exp_end + 4) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    int c, b, ph;
    bit act;
    if (chk_en && cyc != 0) begin
      c = cyc; b = (c - 1) / 10; ph = (c - 1) % 10; act = (c < exp_end);
      chk("finish", int'(m_fin), int'(c == exp_end));
      chk("d_wren", int'(m_dw), int'(act && ph == 9));
      chk("s_wren", int'(m_sw), int'(act && (ph == 5 || ph == 6)));
      if (act && ph == 9) begin
        chk("d_address", int'(m_da), b);
        chk("d_data", int'(m_dd), int'(exp_d[b]));
      end
      if (act && ph == 5) begin
        chk("s_addr_swap_i", int'(m_sa), int'(exp_i[b]));
        chk("s_data_swap_i", int'(m_sd), int'(exp_sj[b]));
      end
      if (act && ph == 6) begin
        chk("s_addr_swap_j", int'(m_sa), int'(exp_j[b]));
        chk("s_data_swap_j", int'(m_sd), int'(exp_si[b]));
      end
      chk("key_ok", int'(m_ok), act ? 0 : int'(exp_ok));
    end
  end

  task automatic identity_s();
    @(negedge clk) init_s = 1'b1;
    @(negedge clk) init_s = 1'b0;
  endtask

  task automatic launch(input int which, input int len, input bit ck);
    sel = which;
    build_model(len, ck);
    chk_en = 1'b1;
    @(negedge clk);
    start = 1'b1; go = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; go = 1'b0;
  endtask

  task automatic wait_run();
    int t = 0;
    while (cyc != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("run_bound", int'(t < 4000), 1);
  endtask

  task automatic wait_cyc(input int target);
    int t = 0;
    while (cyc != target && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cycle_bound", int'(t < 100), 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_s_address"}, int'(m_sa), 0);
    chk({nm, "_s_data"},    int'(m_sd), 0);
    chk({nm, "_s_wren"},    int'(m_sw), 0);
    chk({nm, "_e_address"}, int'(m_ea), 0);
    chk({nm, "_d_address"}, int'(m_da), 0);
    chk({nm, "_d_data"},    int'(m_dd), 0);
    chk({nm, "_d_wren"},    int'(m_dw), 0);
    chk({nm, "_finish"},    int'(m_fin), 0);
    chk({nm, "_key_ok"},    int'(m_ok), 0);
  endtask

  task automatic set_abc();
    emem[0] = 8'h63; emem[1] = 8'h67; emem[2] = 8'h27;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; go = 1'b0; chk_en = 1'b0; sel = 0; init_s = 1'b0;
    for (int n = 0; n < 256; n++) emem[n] = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;

    // Identity S, "ab " message.
    set_abc();
    identity_s();
    launch(0, 3, 1'b1);
    chk("t1_model_end", exp_end, 31);
    wait_run();
    chk("t1_d0", int'(dmem[0]), 8'h61);
    chk("t1_d1", int'(dmem[1]), 8'h62);
    chk("t1_d2", int'(dmem[2]), 8'h20);
    chk("t1_s2", int'(smem[2]), 3);
    chk("t1_s3", int'(smem[3]), 5);
    chk("t1_s5", int'(smem[5]), 2);
    chk("t1_key_ok", int'(m_ok), 1);

    // First byte invalid, aborting configuration.
    emem[0] = 8'h00;
    identity_s();
    launch(0, 3, 1'b1);
    chk("t2_model_end", exp_end, 11);
    wait_run();
    chk("t2_d0", int'(dmem[0]), 8'h02);
    chk("t2_d1_untouched", int'(dmem[1]), 8'hEE);
    chk("t2_key_ok", int'(m_ok), 0);

    // Same stimulus, non-aborting configuration.
    identity_s();
    launch(1, 3, 1'b0);
    wait_run();
    chk("t3_d0", int'(dmem[0]), 8'h02);
    chk("t3_d1", int'(dmem[1]), 8'h62);
    chk("t3_d2", int'(dmem[2]), 8'h20);
    chk("t3_key_ok", int'(m_ok), 1);

    // Full 256-byte message, i wraps on the last byte.
    for (int n = 0; n < 256; n++) emem[n] = 8'(n * 3 + 1);
    identity_s();
    launch(2, 256, 1'b0);
    chk("t4_model_end", exp_end, 2561);
    chk("t4_model_d0", int'(exp_d[0]), 3);
    chk("t4_model_d1", int'(exp_d[1]), 8'h05 ^ 8'h04);
    wait_run();
    chk("t4_key_ok", int'(m_ok), 1);
    chk("t4_d255", int'(dmem[255]), int'(exp_d[255]));

    // Reset during WRITE_I of byte 1, then a clean restart.
    set_abc();
    identity_s();
    launch(0, 3, 1'b1);
    wait_cyc(16);
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    launch(0, 3, 1'b1);
    wait_run();
    chk("t5_d0", int'(dmem[0]), 8'h61);
    chk("t5_d1", int'(dmem[1]), 8'h62);
    chk("t5_d2", int'(dmem[2]), 8'h20);
    chk("t5_s5", int'(smem[5]), 2);
    chk("t5_key_ok", int'(m_ok), 1);

    // start pulsed during READ_J must be ignored.
    identity_s();
    launch(0, 3, 1'b1);
    wait_cyc(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_run();
    chk("t6_key_ok", int'(m_ok), 1);
    chk("t6_d2", int'(dmem[2]), 8'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prga_decrypt.md
# prga_decrypt

Consumer of the shuffled S-array: after the key-schedule shuffler finishes, this block runs the RC4 pseudo-random generation phase over the same 256-byte S memory. It XORs each keystream byte with the encrypted-message ROM, writes the result to the decrypted-message RAM, and checks every byte for plausible plaintext. It sits between the shuffler and the key-search controller, which uses `key_ok` to accept or reject the candidate key.

## Interface
- `MSG_LEN`, 32: message length in bytes (1..256).
- `CHECK_TEXT`, 1: 1 = abort on the first byte outside {8'd97..8'd122, 8'd32}; 0 = never abort.

- `clk` in 1: single clock; everything rises-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin decryption; sampled only in IDLE.
- `s_q` in 8: S memory read data.
- `s_address` out 8: S memory address.
- `s_data` out 8: S memory write data.
- `s_wren` out 1: S memory write enable.
- `e_q` in 8: encrypted ROM read data.
- `e_address` out $clog2(MSG_LEN): encrypted ROM address.
- `d_address` out $clog2(MSG_LEN): decrypted RAM address.
- `d_data` out 8: decrypted RAM write data.
- `d_wren` out 1: decrypted RAM write enable.
- `finish` out 1: one-cycle pulse when the run ends (done or fail).
- `key_ok` out 1: result; valid with `finish`, held until the next accepted `start`.

## Operation
- Internal registers: `i`, `j`, `si`, `sj` (8 bit each) and `k` (message index). All are cleared in IDLE on `start`.
- Per-byte state sequence, one cycle per state:
  - INC: `i<=i+1`, `s_address<=i+1`, `e_address<=k`.
  - WAIT_I.
  - READ_I: `si<=s_q`, `j<=j+s_q`, `s_address<=j+s_q`.
  - WAIT_J.
  - READ_J: `sj<=s_q`, `s_address<=i`, `s_data<=s_q`.
  - WRITE_I (`s_wren`=1): `s_address<=j`, `s_data<=si`.
  - WRITE_J (`s_wren`=1): `s_address<=si+sj`.
  - WAIT_F.
  - READ_F: `d_data<=s_q^e_q`, `d_address<=k`.
  - WRITE_D (`d_wren`=1): check `d_data`.
- WRITE_D exits:
  - Invalid byte and CHECK_TEXT=1: go to FAIL.
  - Otherwise, `k==MSG_LEN-1`: go to DONE.
  - Otherwise: `k<=k+1`, go to INC.
- DONE: `finish`=1, `key_ok<=1`, then IDLE. FAIL: `finish`=1, `key_ok<=0`, then IDLE.
- Arithmetic: all S-index math is mod 256. `i` wraps 255->0; `j` and `si+sj` are truncated to 8 bits.
- When `i==j`: both writes hit the same address and the second (value `si`) wins. This is the correct swap result, so no special case is needed.
- Memories: synchronous, one-cycle read latency. Every read has a wait state; `q` is sampled only in READ_* states.

## Timing
- Reset values: all outputs 0, state IDLE. Reset takes effect mid-run with the same values. S/d RAM contents are not restored.
- `start` accepted at edge E0 → INC occupies cycle 1. Each byte takes exactly 10 cycles.
- DONE (`finish` high) is in cycle 10·MSG_LEN+1. FAIL on byte k is in cycle 10·(k+1)+1.
- `s_wren` is high only in WRITE_I and WRITE_J. `d_wren` is high only in WRITE_D. Address and data are stable throughout each write cycle.
- `start` outside IDLE is ignored. `start` held high re-triggers on the cycle after returning to IDLE.
- `key_ok` changes only in DONE/FAIL and is cleared on accepted `start`.

## Test plan
- Identity S (S[n]=n), MSG_LEN=3, enc={8'h63,8'h67,8'h27}:
  - keystream is 2,5,7; d={'a','b',' '}.
  - `finish` pulses in cycle 31 with `key_ok`=1.
  - S[2]=3, S[3]=5, S[5]=2 afterwards.
- Identity S, enc[0]=8'h00: d[0]=8'h02 (invalid) → FAIL in cycle 11, `key_ok`=0, only d[0] written.
- Same stimulus with CHECK_TEXT=0: runs all MSG_LEN bytes, `key_ok`=1.
- MSG_LEN=256, identity S: `i` wraps 255→0 on byte 255; `finish` in cycle 2561; d matches the software RC4 model.
- `reset_n` low during WRITE_I of byte 1: all outputs 0 immediately, IDLE; the next `start` restarts with `i=j=k=0`.
- `start` pulsed during READ_J: ignored; run completes normally; `finish` pulses exactly once.
